// File: rtl/amstrad_mem_arbiter.sv
// amstrad_mem_arbiter: merges CPU and video fetches onto one single-port memory controller.
// Optional build macro MEM_ARB_WPROT_EN drops CPU writes aimed at the ROM image regions.
module amstrad_mem_arbiter #(
  parameter logic [6:0] VID_BASE = 7'b0000010
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        i_cpu_req,
  input  logic        i_cpu_we,
  input  logic [22:0] i_cpu_addr,
  input  logic [7:0]  i_cpu_din,
  output logic [7:0]  o_cpu_dout,
  output logic        o_cpu_ack,
  input  logic        i_vid_req,
  input  logic [15:0] i_vid_addr,
  output logic [7:0]  o_vid_dout,
  output logic        o_vid_valid,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [22:0] o_mem_addr,
  output logic [7:0]  o_mem_din,
  input  logic [7:0]  i_mem_dout,
  input  logic        i_mem_ready
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DROP = 2'd2;

  logic [1:0]  r_state;
  logic        r_old_req;
  logic        r_cpu_pend;
  logic        r_cpu_we;
  logic [22:0] r_cpu_addr;
  logic [7:0]  r_cpu_din;
  logic        r_vid_pend;
  logic [22:0] r_vid_addr;
  logic        r_last_grant;
  logic        r_grant_vid;

  logic w_cpu_edge;
  logic w_pick_vid;
  logic w_cpu_prot;
  logic w_cpu_done;
  logic w_vid_done;
  logic w_cpu_take;
  logic w_vid_take;

  assign w_cpu_edge = i_cpu_req & ~r_old_req;
  assign w_pick_vid = r_vid_pend & (~r_cpu_pend | ~r_last_grant);
  assign w_cpu_done = ((r_state == S_WAIT) & i_mem_ready & ~r_grant_vid) | (r_state == S_DROP);
  assign w_vid_done = (r_state == S_WAIT) & i_mem_ready & r_grant_vid;
  // A new request landing in the completion cycle replaces the one being retired.
  assign w_cpu_take = w_cpu_edge & (~r_cpu_pend | w_cpu_done);
  assign w_vid_take = i_vid_req & (~r_vid_pend | w_vid_done);

`ifdef MEM_ARB_WPROT_EN
  assign w_cpu_prot = r_cpu_we & ((r_cpu_addr[22:14] == 9'd0) | (r_cpu_addr[22:20] == 3'b001));
`else
  assign w_cpu_prot = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (reset) begin
      r_old_req  <= 1'b0;
      r_cpu_pend <= 1'b0;
      r_cpu_we   <= 1'b0;
      r_cpu_addr <= '0;
      r_cpu_din  <= '0;
      r_vid_pend <= 1'b0;
      r_vid_addr <= '0;
    end else begin
      r_old_req <= i_cpu_req;
      if (w_cpu_take) begin
        r_cpu_pend <= 1'b1;
        r_cpu_we   <= i_cpu_we;
        r_cpu_addr <= i_cpu_addr;
        r_cpu_din  <= i_cpu_din;
      end else if (w_cpu_done) begin
        r_cpu_pend <= 1'b0;
      end
      if (w_vid_take) begin
        r_vid_pend <= 1'b1;
        r_vid_addr <= {VID_BASE, i_vid_addr};
      end else if (w_vid_done) begin
        r_vid_pend <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b0;
      r_grant_vid  <= 1'b0;
      o_mem_req    <= 1'b0;
      o_mem_we     <= 1'b0;
      o_mem_addr   <= '0;
      o_mem_din    <= '0;
      o_cpu_dout   <= '0;
      o_cpu_ack    <= 1'b0;
      o_vid_dout   <= '0;
      o_vid_valid  <= 1'b0;
    end else begin
      o_mem_req   <= 1'b0;
      o_cpu_ack   <= 1'b0;
      o_vid_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_pick_vid) begin
            r_grant_vid  <= 1'b1;
            r_last_grant <= 1'b1;
            o_mem_req    <= 1'b1;
            o_mem_we     <= 1'b0;
            o_mem_addr   <= r_vid_addr;
            o_mem_din    <= '0;
            r_state      <= S_WAIT;
          end else if (r_cpu_pend) begin
            r_grant_vid <= 1'b0;
            // Protected writes are acknowledged without touching memory or the fairness history.
            if (w_cpu_prot) begin
              r_state <= S_DROP;
            end else begin
              r_last_grant <= 1'b0;
              o_mem_req    <= 1'b1;
              o_mem_we     <= r_cpu_we;
              o_mem_addr   <= r_cpu_addr;
              o_mem_din    <= r_cpu_din;
              r_state      <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (i_mem_ready) begin
            r_state <= S_IDLE;
            if (r_grant_vid) begin
              o_vid_dout  <= i_mem_dout;
              o_vid_valid <= 1'b1;
            end else begin
              o_cpu_ack <= 1'b1;
              if (!o_mem_we) o_cpu_dout <= i_mem_dout;
            end
          end
        end
        S_DROP: begin
          o_cpu_ack <= 1'b1;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
